// File: rtl/autosa_sdp_wdma_dat_sched.sv
`default_nettype none
// ============================================================================
// Module  : autosa_sdp_wdma_dat_sched
// Brief   : Schedules WDMA write commands and round-robin FIFO atoms onto the
//           DMA write port; flags layer completion on the last cube-end atom.
// Revision: 1.0
// ============================================================================
module autosa_sdp_wdma_dat_sched #(
  parameter int DW = 64,
  parameter int AW = 29,
  parameter int SW = 13
) (
  input  logic              autosa_core_clk,
  input  logic              autosa_core_rstn,
  input  logic              op_load,
  input  logic              reg2dp_interrupt_ptr,
  input  logic              cmd2dat_dma_pvld,
  output logic              cmd2dat_dma_prdy,
  input  logic [AW+SW+1:0]  cmd2dat_dma_pd,
  input  logic              dfifo0_rd_pvld,
  output logic              dfifo0_rd_prdy,
  input  logic [DW-1:0]     dfifo0_rd_pd,
  input  logic              dfifo1_rd_pvld,
  output logic              dfifo1_rd_prdy,
  input  logic [DW-1:0]     dfifo1_rd_pd,
  input  logic              dfifo2_rd_pvld,
  output logic              dfifo2_rd_prdy,
  input  logic [DW-1:0]     dfifo2_rd_pd,
  input  logic              dfifo3_rd_pvld,
  output logic              dfifo3_rd_prdy,
  input  logic [DW-1:0]     dfifo3_rd_pd,
  output logic              dma_wr_req_vld,
  input  logic              dma_wr_req_rdy,
  output logic [DW+1:0]     dma_wr_req_pd,
  output logic              intr_req_pvld,
  output logic              intr_req_ptr,
  output logic              dp2reg_done
);

  typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   cnt, size_q;
  logic [1:0]      sel;
  logic            cube_q;
  logic            ptr_q;
  logic            done_q;
  logic            out_vld, out_last_end;
  logic [DW+1:0]   out_pd;

  logic            slot_free;
  logic            cmd_take, pop, load, load_last;
  logic [DW+1:0]   load_pd;
  logic [3:0]      fifo_vld, fifo_rdy;
  logic [DW-1:0]   fifo_pd [4];
  logic            unused_odd;

  // The odd flag has no slot in the DMA command packet.
  assign unused_odd = cmd2dat_dma_pd[AW+SW];

  assign fifo_vld   = {dfifo3_rd_pvld, dfifo2_rd_pvld, dfifo1_rd_pvld, dfifo0_rd_pvld};
  assign fifo_pd[0] = dfifo0_rd_pd;
  assign fifo_pd[1] = dfifo1_rd_pd;
  assign fifo_pd[2] = dfifo2_rd_pd;
  assign fifo_pd[3] = dfifo3_rd_pd;

  assign slot_free  = !out_vld || dma_wr_req_rdy;

  always_comb begin
    state_nxt        = state;
    cmd2dat_dma_prdy = 1'b0;
    fifo_rdy         = 4'b0000;
    cmd_take         = 1'b0;
    pop              = 1'b0;
    load             = 1'b0;
    load_last        = 1'b0;
    load_pd          = '0;
    case (state)
      IDLE: begin
        cmd2dat_dma_prdy = slot_free;
        if (cmd2dat_dma_pvld && slot_free) begin
          cmd_take  = 1'b1;
          load      = 1'b1;
          load_pd   = {2'b00, {(DW-AW-SW-1){1'b0}}, cmd2dat_dma_pd[AW+SW+1],
                       cmd2dat_dma_pd[AW+SW-1:AW], cmd2dat_dma_pd[AW-1:0]};
          state_nxt = DATA;
        end
      end
      DATA: begin
        // Ready depends on sel and slot only, so a non-selected FIFO is never popped.
        fifo_rdy[sel] = slot_free;
        if (slot_free && fifo_vld[sel]) begin
          pop     = 1'b1;
          load    = 1'b1;
          load_pd = {2'b01, fifo_pd[sel]};
          if (cnt == size_q) begin
            load_last = cube_q;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) begin
      state        <= IDLE;
      cnt          <= '0;
      size_q       <= '0;
      sel          <= 2'd0;
      cube_q       <= 1'b0;
      ptr_q        <= 1'b0;
      done_q       <= 1'b0;
      out_vld      <= 1'b0;
      out_last_end <= 1'b0;
      out_pd       <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= out_vld && dma_wr_req_rdy && out_last_end;
      if (op_load) ptr_q <= reg2dp_interrupt_ptr;
      if (cmd_take) begin
        size_q <= cmd2dat_dma_pd[AW+SW-1:AW];
        cube_q <= cmd2dat_dma_pd[AW+SW+1];
        cnt    <= '0;
        sel    <= 2'd0;
      end else if (pop) begin
        sel <= sel + 2'd1;
        // Compare before increment so the largest size never overflows cnt.
        if (cnt != size_q) cnt <= cnt + 1'b1;
      end
      if (slot_free) begin
        out_vld      <= load;
        out_last_end <= load_last;
        if (load) out_pd <= load_pd;
      end
    end
  end

  assign dfifo0_rd_prdy = fifo_rdy[0];
  assign dfifo1_rd_prdy = fifo_rdy[1];
  assign dfifo2_rd_prdy = fifo_rdy[2];
  assign dfifo3_rd_prdy = fifo_rdy[3];
  assign dma_wr_req_vld = out_vld;
  assign dma_wr_req_pd  = out_pd;
  assign intr_req_pvld  = done_q;
  assign dp2reg_done    = done_q;
  assign intr_req_ptr   = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_autosa_sdp_wdma_dat_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_autosa_sdp_wdma_dat_sched
// Brief   : Randomized bench with a packet-stream reference model.
// Revision: 1.0
// ============================================================================
module tb_autosa_sdp_wdma_dat_sched;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          op_load = 1'b0;
  logic          ptr_in = 1'b0;
  logic          cmd_pvld = 1'b0;
  wire           cmd_prdy;
  logic [43:0]   cmd_pd = '0;
  logic [3:0]    fvld = 4'b0000;
  wire  [3:0]    fprdy;
  logic [63:0]   fpd [4];
  wire           vld;
  logic          rdy = 1'b0;
  wire  [65:0]   pd;
  wire           intr_pvld, intr_ptr, done;

  autosa_sdp_wdma_dat_sched dut (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn),
    .op_load(op_load), .reg2dp_interrupt_ptr(ptr_in),
    .cmd2dat_dma_pvld(cmd_pvld), .cmd2dat_dma_prdy(cmd_prdy), .cmd2dat_dma_pd(cmd_pd),
    .dfifo0_rd_pvld(fvld[0]), .dfifo0_rd_prdy(fprdy[0]), .dfifo0_rd_pd(fpd[0]),
    .dfifo1_rd_pvld(fvld[1]), .dfifo1_rd_prdy(fprdy[1]), .dfifo1_rd_pd(fpd[1]),
    .dfifo2_rd_pvld(fvld[2]), .dfifo2_rd_prdy(fprdy[2]), .dfifo2_rd_pd(fpd[2]),
    .dfifo3_rd_pvld(fvld[3]), .dfifo3_rd_prdy(fprdy[3]), .dfifo3_rd_pd(fpd[3]),
    .dma_wr_req_vld(vld), .dma_wr_req_rdy(rdy), .dma_wr_req_pd(pd),
    .intr_req_pvld(intr_pvld), .intr_req_ptr(intr_ptr), .dp2reg_done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [65:0] pd; bit last; } pkt_t;
  pkt_t exp_q [$];
  int   sel_q [$];

  int n_vec = 0, n_err = 0;
  int env_idx [4] = '{0, 0, 0, 0};
  int mdl_idx [4] = '{0, 0, 0, 0};
  int vld_pct = 100, rdy_pct = 100;
  logic [3:0] hold = 4'b0000;
  bit   exp_intr = 0, mdl_ptr = 0, prev_rstn = 1, prev_stall = 0, cap_first = 0;
  logic [65:0] prev_pd = '0, first_pkt = '0;
  int   npkt = 0, nintr = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  bit   last_ptr = 0;

  function automatic logic [63:0] atom(input int n, input int j);
    logic [31:0] h;
    h = (j * 32'h9E3779B1) ^ (n * 32'h85EBCA6B);
    return {8'(n), 24'(j), h};
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input logic [65:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h, required nothing (model queue empty)", nm, act);
  endtask

  // FIFO and sink environment: infinite FIFOs whose head is atom(n, pops so far).
  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 4; n++) begin
      fvld[n] = !hold[n] && ($urandom_range(99) < vld_pct);
      fpd[n]  = atom(n, env_idx[n]);
    end
    rdy = ($urandom_range(99) < rdy_pct);
  end

  // Compare process: signals are stable at negedge and equal their values at the next posedge.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      sel_q.delete();
      exp_intr   = 0;
      mdl_ptr    = 0;
      prev_stall = 0;
      for (int n = 0; n < 4; n++) begin
        if (fprdy[n] && fvld[n]) env_idx[n]++;
        mdl_idx[n] = env_idx[n];
      end
    end else begin
      if (!prev_rstn) begin
        chk("rst_vld", vld, 0);
        chk("rst_pd", pd, 0);
        chk("rst_fifo_prdy", fprdy, 0);
      end
      chk("intr_pvld", intr_pvld, exp_intr);
      chk("dp2reg_done", done, exp_intr);
      chk("intr_ptr", intr_ptr, mdl_ptr);
      if (intr_pvld) begin nintr++; last_ptr = intr_ptr; end
      exp_intr = 0;
      if (prev_stall) begin
        chk("hold_vld", vld, 1);
        chk("hold_pd", pd, prev_pd);
      end
      if (vld && !rdy) chk("stall_prdy", {cmd_prdy, fprdy}, 0);
      prev_stall = vld && !rdy;
      prev_pd    = pd;
      if (vld && rdy) begin
        npkt++;
        last_cyc = cyc;
        if (cap_first) begin first_pkt = pd; first_cyc = cyc; cap_first = 0; end
        if (exp_q.size() == 0) fail("pkt_extra", pd);
        else begin
          pkt_t e;
          e = exp_q.pop_front();
          chk("pkt", pd, e.pd);
          if (e.last) exp_intr = 1;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (fprdy[n] && fvld[n]) begin
          env_idx[n]++;
          if (sel_q.size() == 0) fail("pop_extra", 66'(n));
          else chk("pop_fifo", 66'(n), 66'(sel_q.pop_front()));
        end
      end
      if (cmd_pvld && cmd_prdy) begin
        pkt_t p;
        int sz;
        sz   = int'(cmd_pd[41:29]);
        p.pd = '0;
        p.pd[28:0]  = cmd_pd[28:0];
        p.pd[41:29] = cmd_pd[41:29];
        p.pd[42]    = cmd_pd[43];
        p.last      = 0;
        exp_q.push_back(p);
        for (int k = 0; k <= sz; k++) begin
          p.pd   = {2'b01, atom(k % 4, mdl_idx[k % 4])};
          p.last = (k == sz) && cmd_pd[43];
          mdl_idx[k % 4]++;
          sel_q.push_back(k % 4);
          exp_q.push_back(p);
        end
      end
      if (op_load) mdl_ptr = ptr_in;
    end
    prev_rstn = rstn;
    cyc++;
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic send_cmd(input logic [28:0] a, input int sz, input bit ce);
    int k;
    cmd_pvld = 1'b1;
    cmd_pd   = {ce, 1'($urandom_range(1)), 13'(sz), a};
    k = 0;
    while (k < 20000) begin
      @(negedge clk);
      if (cmd_prdy) break;
      k++;
    end
    chk("cmd_accept_in_time", k < 20000, 1);
    @(posedge clk); #1;
    cmd_pvld = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || vld) && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_in_time", k < 20000, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic load_ptr(input bit v);
    op_load = 1'b1;
    ptr_in  = v;
    @(posedge clk); #1;
    op_load = 1'b0;
  endtask

  task automatic clear_counts();
    npkt = 0; nintr = 0; cap_first = 1;
  endtask

  initial begin
    int tot, ncube, sz, snap;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Directed four-atom cube-end command.
    load_ptr(1'b1);
    clear_counts();
    send_cmd(29'h100, 3, 1'b1);
    drain();
    chk("t1_cmd_pkt", first_pkt, 66'h0_0000_0400_6000_0100);
    chk("t1_npkt", npkt, 5);
    chk("t1_nintr", nintr, 1);
    chk("t1_ptr", last_ptr, 1);

    // Six atoms with dfifo2 withheld for a while.
    clear_counts();
    hold[2] = 1'b1;
    send_cmd(29'h1ABCDE, 5, 1'b0);
    snap = env_idx[3];
    repeat (4) begin @(posedge clk); #1; end
    chk("t2_fifo3_unpopped", env_idx[3], snap);
    hold[2] = 1'b0;
    drain();
    chk("t2_npkt", npkt, 7);
    chk("t2_nintr", nintr, 0);

    // Random commands with random ready/valid and pointer updates.
    vld_pct = 70; rdy_pct = 50;
    clear_counts();
    tot = 0; ncube = 0;
    for (int i = 0; i < 12; i++) begin
      bit ce;
      sz = $urandom_range(20);
      ce = 1'($urandom_range(1));
      tot += sz + 2;
      ncube += ce;
      if ($urandom_range(3) == 0) load_ptr(1'($urandom_range(1)));
      send_cmd(29'($urandom), sz, ce);
      if ($urandom_range(1) == 0) drain();
    end
    drain();
    chk("t3_npkt", npkt, tot);
    chk("t3_nintr", nintr, ncube);

    // Back-to-back commands with rdy held high.
    vld_pct = 100; rdy_pct = 100;
    repeat (2) begin @(posedge clk); #1; end
    clear_counts();
    send_cmd(29'h200, 0, 1'b0);
    send_cmd(29'h300, 1, 1'b1);
    drain();
    chk("t4_npkt", npkt, 5);
    chk("t4_contiguous", last_cyc - first_cyc, 4);
    chk("t4_nintr", nintr, 1);

    // Reset in the middle of a transfer, then a clean command.
    send_cmd(29'h400, 20, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_busy_before_rst", vld, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_counts();
    send_cmd(29'h500, 2, 1'b1);
    drain();
    chk("t5_npkt", npkt, 4);
    chk("t5_nintr", nintr, 1);

    // Maximum size with a pointer reload mid-transfer.
    load_ptr(1'b0);
    clear_counts();
    send_cmd(29'h1FFFFFFF, 8191, 1'b1);
    repeat (100) begin @(posedge clk); #1; end
    load_ptr(1'b1);
    drain();
    chk("t6_npkt", npkt, 8193);
    chk("t6_nintr", nintr, 1);
    chk("t6_ptr", last_ptr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
